// File: rtl/stream_cycle_monitor.sv
// stream_cycle_monitor: per-channel ready/valid stream start/end detection with cycle, transfer, stall counters and sticky inactivity timeout
module stream_cycle_monitor #(
  parameter int NUM_CH = 3,
  parameter int DATA_WIDTH = 17,
  parameter logic [DATA_WIDTH-1:0] DONE_TOKEN = 17'h10100,
  parameter int COUNT_WIDTH = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clk_en,
  input  logic                          flush,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  ch_data,
  input  logic [NUM_CH-1:0]             ch_valid,
  input  logic [NUM_CH-1:0]             ch_ready,
  output logic [NUM_CH*COUNT_WIDTH-1:0] cycle_count,
  output logic [NUM_CH*COUNT_WIDTH-1:0] xfer_count,
  output logic [NUM_CH*COUNT_WIDTH-1:0] stall_count,
  output logic [NUM_CH-1:0]             ch_active,
  output logic [NUM_CH-1:0]             ch_done,
  output logic                          all_done,
  output logic [NUM_CH-1:0]             timeout
);
  localparam int IW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] TMO = IW'(TIMEOUT);
  localparam logic [1:0] S_IDLE = 2'd0, S_ACT = 2'd1, S_DONE = 2'd2;
  logic [NUM_CH-1:0] done_n;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0] st, st_n;
    logic [COUNT_WIDTH-1:0] cyc, xfr, stl;
    logic [IW-1:0] idl, idl_n;
    logic to, to_n, v, r, hs, dn, cnt;
    always_comb begin
      v = ch_valid[i];
      r = ch_ready[i];
      hs = v & r;
      dn = ch_data[i*DATA_WIDTH +: DATA_WIDTH] == DONE_TOKEN;
      cnt = (st == S_IDLE && v) || st == S_ACT;
      st_n = (cnt && hs && dn) ? S_DONE : (st == S_IDLE && v) ? S_ACT : st;
      idl_n = (hs || st == S_IDLE) ? '0 : (st == S_ACT && idl != TMO) ? idl + 1'b1 : idl;
      to_n = (TIMEOUT > 0) && (to || (st == S_ACT && idl_n == TMO));
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        st <= S_IDLE;
        cyc <= '0;
        xfr <= '0;
        stl <= '0;
        idl <= '0;
        to <= 1'b0;
      end else if (clk_en) begin
        if (flush) begin
          st <= S_IDLE;
          cyc <= '0;
          xfr <= '0;
          stl <= '0;
          idl <= '0;
          to <= 1'b0;
        end else begin
          st <= st_n;
          cyc <= cyc + COUNT_WIDTH'(cnt && !(&cyc));
          xfr <= xfr + COUNT_WIDTH'(cnt && hs && !(&xfr));
          stl <= stl + COUNT_WIDTH'(cnt && v && !r && !(&stl));
          idl <= idl_n;
          to <= to_n;
        end
      end
    assign done_n[i] = st_n == S_DONE;
    assign cycle_count[i*COUNT_WIDTH +: COUNT_WIDTH] = cyc;
    assign xfer_count[i*COUNT_WIDTH +: COUNT_WIDTH] = xfr;
    assign stall_count[i*COUNT_WIDTH +: COUNT_WIDTH] = stl;
    assign ch_active[i] = st == S_ACT;
    assign ch_done[i] = st == S_DONE;
    assign timeout[i] = to;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) all_done <= 1'b0;
    else if (clk_en) all_done <= flush ? 1'b0 : &done_n;
endmodule

// File: tb/tb_stream_cycle_monitor.sv
// tb_stream_cycle_monitor: directed scoreboard bench for stream_cycle_monitor
module tb_stream_cycle_monitor;
  localparam logic [16:0] DONE = 17'h10100;
  logic clk = 0, rst_n, clk_en, flush;
  logic [2:0] vld, rdy;
  logic [16:0] dat [3];
  logic [50:0] ch_data;
  logic [95:0] cyc_o, xfr_o, stl_o;
  logic [11:0] cyc_s, xfr_s, stl_s;
  logic [2:0] act_o, dn_o, to_o, act_s, dn_s, to_s;
  logic ad_o, ad_s;
  int checks = 0, errors = 0;
  typedef struct {string tag; int ch; int cyc; int xfr; int stl; bit act; bit dn; bit to; bit ad;} exp_t;
  exp_t q [$];
  assign ch_data = {dat[2], dat[1], dat[0]};
  always #5 clk = ~clk;
  stream_cycle_monitor #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .ch_data(ch_data),
    .ch_valid(vld), .ch_ready(rdy), .cycle_count(cyc_o), .xfer_count(xfr_o),
    .stall_count(stl_o), .ch_active(act_o), .ch_done(dn_o), .all_done(ad_o), .timeout(to_o));
  stream_cycle_monitor #(.COUNT_WIDTH(4), .TIMEOUT(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .ch_data(ch_data),
    .ch_valid(vld), .ch_ready(rdy), .cycle_count(cyc_s), .xfer_count(xfr_s),
    .stall_count(stl_s), .ch_active(act_s), .ch_done(dn_s), .all_done(ad_s), .timeout(to_s));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cmp(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic push(string tag, int ch, int cyc, int xfr, int stl, bit act, bit dn, bit to, bit ad);
    exp_t e;
    e.tag = tag; e.ch = ch; e.cyc = cyc; e.xfr = xfr; e.stl = stl;
    e.act = act; e.dn = dn; e.to = to; e.ad = ad;
    q.push_back(e);
  endtask
  task automatic chk();
    exp_t e;
    if (q.size() == 0) begin
      cmp("scoreboard_empty", 0, 1);
      return;
    end
    e = q.pop_front();
    cmp({e.tag, ".cycle"}, cyc_o[e.ch*32 +: 32], e.cyc);
    cmp({e.tag, ".xfer"}, xfr_o[e.ch*32 +: 32], e.xfr);
    cmp({e.tag, ".stall"}, stl_o[e.ch*32 +: 32], e.stl);
    cmp({e.tag, ".active"}, 32'(act_o[e.ch]), 32'(e.act));
    cmp({e.tag, ".done"}, 32'(dn_o[e.ch]), 32'(e.dn));
    cmp({e.tag, ".timeout"}, 32'(to_o[e.ch]), 32'(e.to));
    cmp({e.tag, ".all_done"}, 32'(ad_o), 32'(e.ad));
  endtask
  task automatic do_flush();
    vld = 0;
    flush = 1;
    tick();
    flush = 0;
  endtask
  initial begin
    logic [16:0] toks [5];
    toks = '{17'h1, 17'h2, 17'h10000, 17'h4, DONE};
    rst_n = 0; clk_en = 1; flush = 0; vld = 0; rdy = 0;
    dat = '{17'h0, 17'h0, 17'h0};
    repeat (2) tick();
    for (int j = 0; j < 3; j++) begin
      push("reset", j, 0, 0, 0, 0, 0, 0, 0);
      chk();
    end
    rst_n = 1;
    // single stream on channel 0, valid from cycle 3, ready always high
    rdy = 3'b111;
    push("ready_only", 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk();
    for (int k = 1; k <= 6; k++) begin
      dat[0] = k == 6 ? DONE : 17'(k);
      vld[0] = 1;
      if (k == 5) push("t1_mid", 0, 5, 5, 0, 1, 0, 0, 0);
      if (k == 6) push("t1_end", 0, 6, 6, 0, 0, 1, 0, 0);
      tick();
      if (k >= 5) chk();
    end
    dat[0] = 17'h5;
    push("t1_frozen", 0, 6, 6, 0, 0, 1, 0, 0);
    repeat (2) tick();
    chk();
    do_flush();
    push("t1_flush", 0, 0, 0, 0, 0, 0, 0, 0);
    chk();
    // channel 1 alternating ready, valid held, stop token mid-stream
    for (int k = 0; k <= 8; k++) begin
      vld[1] = 1;
      rdy[1] = k % 2 == 0;
      dat[1] = toks[(k + 1) / 2];
      if (k == 7) push("t2_mid", 1, 8, 4, 4, 1, 0, 0, 0);
      if (k == 8) push("t2_end", 1, 9, 5, 4, 0, 1, 0, 0);
      tick();
      if (k >= 7) chk();
    end
    rdy = 3'b111;
    do_flush();
    // single-token stream on channel 2
    dat[2] = DONE;
    vld[2] = 1;
    push("t3_single", 2, 1, 1, 0, 0, 1, 0, 0);
    tick();
    chk();
    do_flush();
    // inactivity timeout on channel 0
    dat[0] = 17'h1;
    vld[0] = 1;
    tick();
    vld[0] = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 7) push("t4_idle7", 0, 8, 1, 0, 1, 0, 0, 0);
      if (k == 8) push("t4_idle8", 0, 9, 1, 0, 1, 0, 1, 0);
      tick();
      if (k >= 7) chk();
    end
    cmp("t4_timeout_disabled", 32'(to_s[0]), 0);
    dat[0] = 17'h2;
    vld[0] = 1;
    push("t4_sticky", 0, 10, 2, 0, 1, 0, 1, 0);
    tick();
    chk();
    // async reset pulse mid-cycle while channel 0 is active
    #3 rst_n = 0;
    #1 push("t6_async", 0, 0, 0, 0, 0, 0, 0, 0);
    chk();
    rst_n = 1;
    dat[0] = 17'h3;
    push("t6_restart_rst", 0, 1, 1, 0, 1, 0, 0, 0);
    tick();
    chk();
    tick();
    do_flush();
    push("t6_flush", 0, 0, 0, 0, 0, 0, 0, 0);
    chk();
    vld[0] = 1;
    push("t6_restart_flush", 0, 1, 1, 0, 1, 0, 0, 0);
    tick();
    chk();
    do_flush();
    // three channels ending at counting cycles 10/20/30 with a 5-cycle freeze
    vld = 3'b111;
    for (int c = 1; c <= 30; c++) begin
      if (c == 6) begin
        clk_en = 0;
        flush = 1;
        push("t5_freeze", 0, 5, 5, 0, 1, 0, 0, 0);
        repeat (5) tick();
        chk();
        flush = 0;
        clk_en = 1;
      end
      for (int j = 0; j < 3; j++) dat[j] = c == 10 * (j + 1) ? DONE : 17'(c);
      if (c == 10) push("t5_ch0", 0, 10, 10, 0, 0, 1, 0, 0);
      if (c == 29) push("t5_ch2_pre", 2, 29, 29, 0, 1, 0, 0, 0);
      if (c == 30) push("t5_ch2", 2, 30, 30, 0, 0, 1, 0, 1);
      if (c == 30) push("t5_ch1", 1, 20, 20, 0, 0, 1, 0, 1);
      tick();
      if (c == 10 || c == 29) chk();
      if (c == 30) begin
        chk();
        chk();
      end
    end
    cmp("sat_ch0_cycle", 32'(cyc_s[3:0]), 10);
    cmp("sat_ch1_cycle", 32'(cyc_s[7:4]), 15);
    cmp("sat_ch1_xfer", 32'(xfr_s[7:4]), 15);
    cmp("sat_ch2_cycle", 32'(cyc_s[11:8]), 15);
    cmp("sat_all_done", 32'(ad_s), 1);
    cmp("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_cycle_monitor.md
Name: stream_cycle_monitor

Overview:
- Parametrised, synthesizable performance monitor for NUM_CH ready/valid token streams.
- Passively taps the stream ports of a fiber-access, scanner or GLB interface in unit benches and on-chip debug.
- Per channel, detects stream start (first valid) and stream end (handshake of the done token).
- Per channel, counts active cycles, transfers and back-pressure stall cycles, and flags a sticky inactivity timeout.
- Generalises the single-channel write/read cycle counting used in sparse unit tests to N channels, with saturation and timeout.

Parameters:
- NUM_CH, 3, number of monitored streams.
- DATA_WIDTH, 17, token width (bit 16 = control flag).
- DONE_TOKEN, 17'h10100, value whose handshake ends a stream.
- COUNT_WIDTH, 32, width of each counter; counters saturate at all-ones.
- TIMEOUT, 1024, idle cycles (no handshake while ACTIVE) before timeout asserts; 0 disables.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  global clock enable; low freezes all state
- flush  in  1  synchronous clear of all state, priority over all other inputs
- ch_data  in  NUM_CH*DATA_WIDTH  tapped token data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- ch_valid  in  NUM_CH  tapped valid
- ch_ready  in  NUM_CH  tapped ready
- cycle_count  out  NUM_CH*COUNT_WIDTH  active cycles per channel
- xfer_count  out  NUM_CH*COUNT_WIDTH  handshakes (valid&ready) per channel
- stall_count  out  NUM_CH*COUNT_WIDTH  cycles with valid&!ready while counting
- ch_active  out  NUM_CH  channel in ACTIVE
- ch_done  out  NUM_CH  channel in DONE
- all_done  out  1  AND of ch_done
- timeout  out  NUM_CH  sticky inactivity flag

Behaviour:
- Reset (rst_n low, async): all counters 0, states IDLE, ch_active/ch_done/timeout 0, all_done 0.
- flush high on a clk_en cycle: same values as reset, applied synchronously.
- clk_en low: no state or counter changes; flush is ignored.
- All outputs are registered. Effect of cycle N inputs is visible after edge N.
- Per-channel FSM; hs = valid&ready; is_done = (data == DONE_TOKEN).
- IDLE -> ACTIVE on valid, unless hs&is_done.
- IDLE -> DONE on valid & hs & is_done (single-token stream).
- ACTIVE -> DONE on hs & is_done.
- DONE holds until flush/reset; later valid and data are ignored and counters stay frozen.
- Counting applies to "counting cycles": the cycle leaving IDLE, every ACTIVE cycle, and the cycle of the done handshake.
  - cycle_count +1 per counting cycle.
  - xfer_count +1 per counting cycle with hs.
  - stall_count +1 per counting cycle with valid & !ready.
- ready without valid in IDLE: no start, no counting.
- Saturation: a counter at 2^COUNT_WIDTH-1 holds its value; no wrap.
- Timeout: per-channel idle counter, clog2(TIMEOUT+1) bits.
  - Cleared on any hs and on entering ACTIVE.
  - Increments each ACTIVE cycle without hs.
  - timeout[i] sets when the idle counter reaches TIMEOUT; stays set until flush/reset.
  - Counting continues after timeout.
  - TIMEOUT=0: timeout tied 0.
- Channels are fully independent. all_done registers from the next-state ch_done, so it rises in the same cycle as the last ch_done.
- Control tokens other than DONE_TOKEN (e.g. stop tokens 17'h1000x) count as ordinary transfers.

Test Plan:
- Single channel, 5 data tokens then 17'h10100, ready always 1, valid from cycle 3 -> cycle_count=6, xfer_count=6, stall_count=0, ch_done rises after the 6th handshake.
- Channel 1 alternates ready 1/0 across 4 tokens + done, valid held -> xfer_count=5, stall_count=4, cycle_count=9.
- First token is 17'h10100 with ready=1 -> IDLE->DONE directly, cycle_count=1, xfer_count=1, ch_active never asserted.
- TIMEOUT=8: start, then valid=0 for 8 cycles -> timeout[i]=1 on the 8th idle cycle and stays 1 after later traffic.
- NUM_CH=3, channels finish at cycles 10/20/30; clk_en low for 5 cycles mid-stream -> counts exclude frozen cycles; all_done rises with the last ch_done.
- flush mid-stream and async rst_n pulse mid-stream -> all outputs 0; next valid restarts counting from 1.
- COUNT_WIDTH=4 with a 20-cycle stream -> cycle_count saturates at 15.
